// File: rtl/branch_unit_if.sv
// Execute-stage to branch-unit bus: input handshake, operands, flags and registered result.
interface branch_unit_if #(
  parameter int unsigned SIZE = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic [2:0]      funct3;
  logic            EQ;
  logic            GT_SN;
  logic            LT_SN;
  logic            GT_UN;
  logic            LT_UN;
  logic [SIZE-1:0] pc;
  logic [SIZE-1:0] imm;
  logic [SIZE-1:0] alu_res;
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic            misaligned;
  logic            illegal;
  logic [SIZE-1:0] target;
  logic [SIZE-1:0] link;
  logic            redirect;

  // Producer/consumer side that drives the operands and accepts the result.
  modport master (
    output in_valid, is_branch, is_jal, is_jalr, funct3,
           EQ, GT_SN, LT_SN, GT_UN, LT_UN, pc, imm, alu_res, out_ready,
    input  in_ready, out_valid, taken, misaligned, illegal, target, link, redirect
  );

  // Branch unit side.
  modport slave (
    input  in_valid, is_branch, is_jal, is_jalr, funct3,
           EQ, GT_SN, LT_SN, GT_UN, LT_UN, pc, imm, alu_res, out_ready,
    output in_ready, out_valid, taken, misaligned, illegal, target, link, redirect
  );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates branch/JAL/JALR, registers the decision in a
// single-entry pipeline register and discards wrong-path inputs after a redirect.
module branch_unit #(
  parameter int unsigned SIZE       = 64,
  parameter int unsigned SHADOW_LEN = 2
) (
  input logic         clk,
  input logic         rst_n,
  branch_unit_if.slave bu
);

  localparam int unsigned CNT_W = (SHADOW_LEN == 0) ? 1 : $clog2(SHADOW_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SHADOW_LEN);

  typedef enum logic {NORMAL, SHADOW} state_t;

  typedef struct packed {
    logic            taken;
    logic            misaligned;
    logic            illegal;
    logic [SIZE-1:0] target;
    logic [SIZE-1:0] link;
  } result_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  result_t          res_q, res_d;
  logic             out_valid_q;

  logic             br_cond_c;
  logic             br_illegal_c;
  logic             cond_c;
  logic [SIZE-1:0]  tgt_c;
  logic             accept_c;
  logic             load_c;
  logic             in_ready_c;

  // GT flags are redundant with EQ/LT, and bit 0 of a JALR sum is always cleared.
  logic unused_inputs;
  assign unused_inputs = ^{bu.GT_SN, bu.GT_UN, bu.alu_res[0]};

  // Condition decode and target/link computation for the incoming instruction.
  always_comb begin
    br_cond_c    = 1'b0;
    br_illegal_c = 1'b0;
    case (bu.funct3)
      3'b000:         br_cond_c    = bu.EQ;
      3'b001:         br_cond_c    = ~bu.EQ;
      3'b100:         br_cond_c    = bu.LT_SN;
      3'b101:         br_cond_c    = ~bu.LT_SN;
      3'b110:         br_cond_c    = bu.LT_UN;
      3'b111:         br_cond_c    = ~bu.LT_UN;
      default:        br_illegal_c = 1'b1;
    endcase

    cond_c = bu.is_jal | bu.is_jalr | (bu.is_branch & br_cond_c);
    tgt_c  = bu.is_jalr ? {bu.alu_res[SIZE-1:1], 1'b0} : bu.pc + bu.imm;

    res_d.illegal    = bu.is_branch & br_illegal_c;
    res_d.misaligned = cond_c & (tgt_c[1:0] != 2'b00);
    res_d.taken      = cond_c & (tgt_c[1:0] == 2'b00);
    res_d.target     = tgt_c;
    res_d.link       = bu.pc + SIZE'(4);
  end

  // Handshake: SHADOW always swallows inputs; NORMAL has full-throughput backpressure.
  assign in_ready_c = (state_q == SHADOW) | ~out_valid_q | bu.out_ready;
  assign accept_c   = bu.in_valid & in_ready_c;
  assign load_c     = accept_c & (state_q == NORMAL);

  // Next-state logic for the wrong-path shadow after a taken result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      NORMAL: begin
        if (load_c && res_d.taken && (SHADOW_LEN != 0)) begin
          state_d = SHADOW;
          cnt_d   = CNT_INIT;
        end
      end
      SHADOW: begin
        if (accept_c) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = NORMAL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = NORMAL;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and shadow counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single-entry result register; a same-cycle consume and load replaces the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      if (load_c) begin
        out_valid_q <= 1'b1;
        res_q       <= res_d;
      end else if (bu.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bu.in_ready   = in_ready_c;
  assign bu.out_valid  = out_valid_q;
  assign bu.taken      = res_q.taken;
  assign bu.misaligned = res_q.misaligned;
  assign bu.illegal    = res_q.illegal;
  assign bu.target     = res_q.target;
  assign bu.link       = res_q.link;
  assign bu.redirect   = out_valid_q & bu.out_ready & res_q.taken;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit with a reference model of the handshake and shadow.
module tb_branch_unit;
  localparam int unsigned SIZE = 64;
  localparam int unsigned SL   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_unit_if #(.SIZE(SIZE)) bu ();

  branch_unit #(.SIZE(SIZE), .SHADOW_LEN(SL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bu   (bu)
  );

  typedef struct {
    logic        v, br, jal, jalr;
    logic [2:0]  f3;
    logic        eq, lts, ltu;
    logic [63:0] pc, imm, alu;
  } stim_t;

  typedef struct {
    logic        taken, mis, ill, chk_tgt;
    logic [63:0] target, link;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  bit   m_ov     = 1'b0;
  bit   m_shadow = 1'b0;
  int   m_cnt    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic br, jal, jalr, input logic [2:0] f3,
                               input logic eq, lts, ltu,
                               input logic [63:0] pc, imm, alu);
    stim_t s;
    s.v = 1'b1; s.br = br; s.jal = jal; s.jalr = jalr; s.f3 = f3;
    s.eq = eq; s.lts = lts; s.ltu = ltu; s.pc = pc; s.imm = imm; s.alu = alu;
    return s;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    s.v = 1'b0;
    return s;
  endfunction

  // Reference behaviour of one instruction.
  function automatic exp_t exp_of(input stim_t s);
    exp_t        e;
    logic        c = 1'b0;
    logic [63:0] t;
    e.ill  = 1'b0;
    e.link = s.pc + 64'd4;
    if (s.br) begin
      case (s.f3)
        3'd0: c = s.eq;
        3'd1: c = !s.eq;
        3'd4: c = s.lts;
        3'd5: c = !s.lts;
        3'd6: c = s.ltu;
        3'd7: c = !s.ltu;
        default: e.ill = 1'b1;
      endcase
    end else if (s.jal || s.jalr) begin
      c = 1'b1;
    end
    t = s.jalr ? (s.alu & ~64'd1) : s.pc + s.imm;
    e.target  = t;
    e.chk_tgt = c;
    e.mis     = c && (t % 4 != 0);
    e.taken   = c && (t % 4 == 0);
    return e;
  endfunction

  task automatic apply(input stim_t s);
    bu.in_valid  = s.v;
    bu.is_branch = s.br;
    bu.is_jal    = s.jal;
    bu.is_jalr   = s.jalr;
    bu.funct3    = s.f3;
    bu.EQ        = s.eq;
    bu.LT_SN     = s.lts;
    bu.LT_UN     = s.ltu;
    bu.GT_SN     = ~s.eq & ~s.lts;
    bu.GT_UN     = ~s.eq & ~s.ltu;
    bu.pc        = s.pc;
    bu.imm       = s.imm;
    bu.alu_res   = s.alu;
  endtask

  // One clock cycle: drive on the falling edge, check outputs, advance the model.
  task automatic cycle(input stim_t s, input logic ordy);
    exp_t e;
    bit   exp_rdy;
    @(negedge clk);
    apply(s);
    bu.out_ready = ordy;
    #1;
    exp_rdy = m_shadow || !m_ov || ordy;
    check("in_ready", bu.in_ready, exp_rdy);
    if (m_ov) begin
      e = sb[0];
      check("out_valid", bu.out_valid, 1);
      check("taken", bu.taken, e.taken);
      check("misaligned", bu.misaligned, e.mis);
      check("illegal", bu.illegal, e.ill);
      check("link", bu.link, e.link);
      if (e.chk_tgt) check("target", bu.target, e.target);
      check("redirect", bu.redirect, ordy & e.taken);
      if (ordy) begin
        void'(sb.pop_front());
        m_ov = 1'b0;
      end
    end else begin
      check("out_valid_idle", bu.out_valid, 0);
      check("redirect_idle", bu.redirect, 0);
    end
    if (s.v && exp_rdy) begin
      if (m_shadow) begin
        m_cnt--;
        if (m_cnt == 0) m_shadow = 1'b0;
      end else begin
        e = exp_of(s);
        sb.push_back(e);
        m_ov = 1'b1;
        if (e.taken && SL > 0) begin
          m_shadow = 1'b1;
          m_cnt    = SL;
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, bu.out_valid, 0);
    check({tag, "_taken"}, bu.taken, 0);
    check({tag, "_misaligned"}, bu.misaligned, 0);
    check({tag, "_illegal"}, bu.illegal, 0);
    check({tag, "_target"}, bu.target, 0);
    check({tag, "_link"}, bu.link, 0);
    check({tag, "_redirect"}, bu.redirect, 0);
  endtask

  stim_t nocls;
  stim_t r;

  initial begin
    nocls = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 64'h500, 64'h4, 64'd0);

    rst_n = 1'b0;
    apply(idle());
    bu.out_ready = 1'b0;
    #3;
    check_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // BEQ taken, held one cycle, then three valid inputs: two dropped, third kept.
    cycle(mk(1, 0, 0, 3'b000, 1, 0, 0, 64'h1000, 64'h40, 0), 1'b0);
    cycle(nocls, 1'b0);
    check("beq_target", bu.target, 64'h1040);
    check("beq_link", bu.link, 64'h1004);
    check("beq_taken", bu.taken, 1);
    check("shadow_ready_no_ordy", bu.in_ready, 1);
    cycle(nocls, 1'b1);
    check("beq_redirect", bu.redirect, 1);
    // BLTU not taken then BGEU taken back-to-back.
    cycle(mk(1, 0, 0, 3'b110, 0, 0, 0, 64'h2000, 64'h8, 0), 1'b1);
    cycle(mk(1, 0, 0, 3'b111, 0, 0, 0, 64'h2004, 64'h8, 0), 1'b1);
    check("bltu_taken", bu.taken, 0);
    check("bltu_out_valid", bu.out_valid, 1);
    cycle(nocls, 1'b1);
    check("bgeu_taken", bu.taken, 1);
    check("bgeu_target", bu.target, 64'h200C);
    cycle(nocls, 1'b1);
    // JALR and JAL with misaligned targets.
    cycle(mk(0, 0, 1, 3'd0, 0, 0, 0, 64'h300, 0, 64'h2003), 1'b1);
    cycle(mk(0, 1, 0, 3'd0, 0, 0, 0, 64'h0, 64'h6, 0), 1'b1);
    check("jalr_target", bu.target, 64'h2002);
    check("jalr_mis", bu.misaligned, 1);
    check("jalr_taken", bu.taken, 0);
    cycle(mk(0, 0, 0, 3'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0), 1'b1);
    check("jal_mis", bu.misaligned, 1);
    // Backpressure: four cycles with out_ready low, result must hold.
    for (int i = 0; i < 4; i++) begin
      cycle(mk(1, 0, 0, 3'b001, 0, 0, 0, 64'h700, 64'h10, 0), 1'b0);
      check("hold_link_wrap", bu.link, 64'd0);
      check("hold_in_ready", bu.in_ready, 0);
    end
    cycle(mk(1, 0, 0, 3'b010, 1, 0, 0, 64'h800, 64'h10, 0), 1'b1);
    cycle(mk(1, 0, 0, 3'b011, 0, 1, 1, 64'h900, 64'h10, 0), 1'b1);
    check("illegal_010", bu.illegal, 1);
    check("illegal_taken", bu.taken, 0);
    cycle(idle(), 1'b1);

    // Taken JAL, one drop, then reset mid-shadow with the result still pending.
    cycle(mk(0, 1, 0, 3'd0, 0, 0, 0, 64'h100, 64'h20, 0), 1'b1);
    cycle(nocls, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    apply(idle());
    #1;
    check_zero("midreset");
    sb.delete();
    m_ov = 1'b0; m_shadow = 1'b0; m_cnt = 0;
    #1 rst_n = 1'b1;
    cycle(mk(1, 0, 0, 3'b001, 0, 0, 0, 64'h4000, 64'h20, 0), 1'b0);
    cycle(idle(), 1'b1);
    check("bne_after_reset_taken", bu.taken, 1);
    check("bne_after_reset_target", bu.target, 64'h4020);

    // Random traffic under random backpressure.
    for (int i = 0; i < 150; i++) begin
      int k;
      k = $urandom_range(0, 3);
      r = mk(k == 1, k == 2, k == 3, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             {$urandom(), $urandom()}, 64'($urandom_range(0, 63)), {$urandom(), $urandom()});
      r.v = ($urandom_range(0, 3) != 0);
      cycle(r, 1'($urandom_range(0, 3) != 0));
    end
    cycle(idle(), 1'b1);
    cycle(idle(), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
